key_serial_tx: RTL



---
 rtl/key_serial_tx.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/key_serial_tx.sv
// key_serial_tx: shifts a captured key word out one bit per ready/valid beat,
// follows it with an even-parity beat, then pulses done for one cycle.
// Every output comes straight from a flop.
module key_serial_tx #(
    parameter int KEY_W     = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             C,
    input  logic             R,
    input  logic             start,
    input  logic [KEY_W-1:0] key,
    input  logic             srdy,
    output logic             sd,
    output logic             sv,
    output logic             sp,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(KEY_W + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(KEY_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        PAR  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               par_q,   par_d;
    logic               sd_q,    sd_d;
    logic               sv_q,    sv_d;
    logic               sp_q,    sp_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    logic               head_q;
    logic               head_d;
    logic               xfer;

    // The head bit is what is on the wire now; a beat moves when the
    // registered valid meets the receiver's ready.
    always_comb begin
        head_q = MSB_FIRST ? shift_q[KEY_W-1] : shift_q[0];
        xfer   = sv_q & srdy;
    end

    // Next-state logic, then the registered outputs are derived from the
    // next state so that they line up with the state they describe.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = key;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (MSB_FIRST) begin
                        shift_d = {shift_q[KEY_W-2:0], 1'b0};
                    end else begin
                        shift_d = {1'b0, shift_q[KEY_W-1:1]};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    par_d = par_q ^ head_q;
                    if (cnt_q == LAST_IDX) begin
                        state_d = PAR;
                    end
                end
            end
            PAR: begin
                if (xfer) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        head_d = MSB_FIRST ? shift_d[KEY_W-1] : shift_d[0];

        sv_d   = (state_d == SEND) || (state_d == PAR);
        sp_d   = (state_d == PAR);
        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
        if (state_d == SEND) begin
            sd_d = head_d;
        end else if (state_d == PAR) begin
            sd_d = par_d;
        end else begin
            sd_d = 1'b0;
        end
    end

    // State and output registers; reset wins over everything, including a beat in flight.
    always_ff @(posedge C) begin
        if (R) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            sd_q    <= 1'b0;
            sv_q    <= 1'b0;
            sp_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            sd_q    <= sd_d;
            sv_q    <= sv_d;
            sp_q    <= sp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sd   = sd_q;
    assign sv   = sv_q;
    assign sp   = sp_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
